// File: rtl/pifo_seq_pkg.sv
// Shared definitions for the PIFO traffic sequencer.
//   state_t      : sequencer FSM states
//   LFSR_TAPS    : Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
//   DEFAULT_SEED : LFSR start value
//   lfsr_step()  : one Galois step of the 16-bit LFSR
package pifo_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PUSH  = 3'd1,
    S_GAP   = 3'd2,
    S_POP   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/pifo_seq_lfsr.sv
// 16-bit Galois LFSR used as the priority source.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset, loads SEED
//   load  : reload SEED (wins over step)
//   step  : advance one step
//   value : current LFSR state
import pifo_seq_pkg::*;

module pifo_seq_lfsr #(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      value <= SEED;
    end else if (step) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/pifo_traffic_sequencer.sv
// PIFO traffic sequencer: pushes N pseudo-random priorities, waits GAP_CYC
// cycles, pops N entries and checks that popped priorities never decrease.
// Optional build macro: PIFO_SEQ_SUMCHECK_EN adds pushed/popped priority sum
// comparison at end of run.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_start      : start a run (taken in IDLE or DONE)
//   i_num_ops    : pushes (= pops) per run, latched on start
//   i_ready      : PIFO accepts the presented command this cycle
//   o_push/o_pop : registered commands, never high together
//   o_data       : push payload {push index, prio}
//   i_data       : pop result, sampled POP_LAT cycles after an accepted pop
//   o_busy       : run in progress (PUSH/GAP/POP/DRAIN)
//   o_done       : one-cycle end-of-run pulse
//   o_err        : sticky error flag
//   o_err_cnt    : saturating ordering-violation count
//   o_pop_cnt    : number of pop results checked
//   o_state      : current FSM state (debug)
// Handshake: a command transfers on a rising edge where (o_push|o_pop) and
// i_ready are both high; until then o_push/o_pop/o_data are held unchanged.
import pifo_seq_pkg::*;

module pifo_traffic_sequencer #(
  parameter int          PTW     = 16,
  parameter int          MTW     = 32,
  parameter int          CNTW    = 8,
  parameter int          POP_LAT = 2,
  parameter int          GAP_CYC = 20,
  parameter logic [15:0] SEED    = DEFAULT_SEED
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [CNTW-1:0]      i_num_ops,
  input  logic                 i_ready,
  output logic                 o_push,
  output logic                 o_pop,
  output logic [MTW+PTW-1:0]   o_data,
  input  logic [MTW+PTW-1:0]   i_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [CNTW-1:0]      o_err_cnt,
  output logic [CNTW-1:0]      o_pop_cnt,
  output logic [2:0]           o_state
);

  state_t             state, state_nx;
  logic [CNTW-1:0]    num_ops;
  logic [CNTW-1:0]    op_cnt;
  logic [15:0]        tmr;
  logic               push_q, pop_q, busy_q, done_q;
  logic [MTW+PTW-1:0] data_q;
  logic [15:0]        lfsr_val;
  logic [15:0]        lfsr_nx;

  logic               acc_push, acc_pop, start_ok, last_op;

  logic [POP_LAT-1:0] vld;
  logic               emit;
  logic [PTW-1:0]     pop_prio;
  logic [PTW-1:0]     prev_prio;
  logic               err_q;
  logic [CNTW-1:0]    err_cnt_q, pop_cnt_q;
  logic               order_viol;
  logic               sum_viol;
  logic               unused_meta;

  assign acc_push = push_q & i_ready;
  assign acc_pop  = pop_q & i_ready;
  assign start_ok = i_start & ((state == S_IDLE) | (state == S_DONE));
  assign last_op  = (op_cnt == num_ops - 1'b1);
  assign lfsr_nx  = lfsr_step(lfsr_val);

  pifo_seq_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (i_clk),
    .rst   (i_rst),
    .load  (start_ok),
    .step  (acc_push),
    .value (lfsr_val)
  );

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nx = (i_num_ops == '0) ? S_DONE : S_PUSH;
      end
      S_DONE: begin
        if (start_ok) state_nx = (i_num_ops == '0) ? S_DONE : S_PUSH;
        else          state_nx = S_IDLE;
      end
      S_PUSH: begin
        if (acc_push && last_op) state_nx = (GAP_CYC == 0) ? S_POP : S_GAP;
      end
      S_GAP: begin
        if (tmr == 16'(GAP_CYC - 1)) state_nx = S_POP;
      end
      S_POP: begin
        if (acc_pop && last_op) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (tmr == 16'(POP_LAT - 1)) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register and command generation. The command/status flops are
  // loaded from state_nx so they line up exactly with the state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      num_ops <= '0;
      op_cnt  <= '0;
      tmr     <= '0;
      data_q  <= '0;
    end else begin
      state  <= state_nx;
      push_q <= (state_nx == S_PUSH);
      pop_q  <= (state_nx == S_POP);
      busy_q <= (state_nx inside {S_PUSH, S_GAP, S_POP, S_DRAIN});
      done_q <= (state_nx == S_DONE);

      if (start_ok) num_ops <= i_num_ops;

      if (start_ok) begin
        op_cnt <= '0;
      end else if (acc_push || acc_pop) begin
        op_cnt <= last_op ? '0 : op_cnt + 1'b1;
      end

      if (state_nx != state) begin
        tmr <= '0;
      end else if (state == S_GAP || state == S_DRAIN) begin
        tmr <= tmr + 16'd1;
      end

      // Payload for the next push is prepared when the current one transfers,
      // so it is already in place in the cycle the command is presented.
      if (start_ok) begin
        data_q <= (i_num_ops == '0) ? '0 : {MTW'(0), SEED[PTW-1:0]};
      end else if (acc_push) begin
        data_q <= last_op ? '0 : {MTW'(op_cnt + 1'b1), lfsr_nx[PTW-1:0]};
      end
    end
  end

  // Ordering checker
  assign emit       = vld[POP_LAT-1];
  assign pop_prio   = i_data[PTW-1:0];
  assign order_viol = emit && (pop_cnt_q != '0) && (pop_prio < prev_prio);
  assign unused_meta = ^i_data[MTW+PTW-1:PTW];

`ifdef PIFO_SEQ_SUMCHECK_EN
  localparam int SUMW = PTW + CNTW;
  logic [SUMW-1:0] sum_push, sum_pop, sum_pop_nx;

  assign sum_pop_nx = sum_pop + (emit ? SUMW'(pop_prio) : '0);
  // The final result lands on the DRAIN->DONE edge, so fold it in here to
  // have o_err valid during the DONE cycle.
  assign sum_viol   = (state == S_DRAIN) && (state_nx == S_DONE) &&
                      (sum_push != sum_pop_nx);

  always_ff @(posedge i_clk) begin
    if (i_rst || start_ok) begin
      sum_push <= '0;
      sum_pop  <= '0;
    end else begin
      if (acc_push) sum_push <= sum_push + SUMW'(data_q[PTW-1:0]);
      sum_pop <= sum_pop_nx;
    end
  end
`else
  assign sum_viol = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst || start_ok) begin
      vld       <= '0;
      prev_prio <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      pop_cnt_q <= '0;
    end else begin
      vld   <= (vld << 1) | POP_LAT'(acc_pop);
      err_q <= err_q | order_viol | sum_viol;
      if (order_viol && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
      if (emit) begin
        prev_prio <= pop_prio;
        pop_cnt_q <= pop_cnt_q + 1'b1;
      end
    end
  end

  assign o_push    = push_q;
  assign o_pop     = pop_q;
  assign o_data    = data_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;
  assign o_pop_cnt = pop_cnt_q;
  assign o_state   = state;

endmodule

// File: tb/tb_pifo_traffic_sequencer.sv
// Bench for pifo_traffic_sequencer with a behavioural min-PIFO (POP_LAT=2).
module tb_pifo_traffic_sequencer;

  localparam int PTW  = 16;
  localparam int MTW  = 32;
  localparam int CNTW = 8;
  localparam int DW   = MTW + PTW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            i_start = 1'b0;
  logic [CNTW-1:0] i_num_ops = '0;
  logic            i_ready = 1'b0;
  logic [DW-1:0]   i_data;
  logic            o_push, o_pop, o_busy, o_done, o_err;
  logic [DW-1:0]   o_data;
  logic [CNTW-1:0] o_err_cnt, o_pop_cnt;
  logic [2:0]      o_state;

  pifo_traffic_sequencer dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (i_start),
    .i_num_ops (i_num_ops),
    .i_ready   (i_ready),
    .o_push    (o_push),
    .o_pop     (o_pop),
    .o_data    (o_data),
    .i_data    (i_data),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_err_cnt (o_err_cnt),
    .o_pop_cnt (o_pop_cnt),
    .o_state   (o_state)
  );

  // behavioural PIFO: min-first (or FIFO when fifo_mode), 2-cycle pop latency
  logic        fifo_mode = 1'b0;
  int          corrupt_idx = -1;
  logic [15:0] m_q[$];
  int          m_pops;
  logic [DW-1:0] p0;

  always @(posedge clk) begin : pifo_model
    int idx;
    logic [15:0] r;
    if (rst) begin
      m_q.delete();
      m_pops = 0;
      p0     <= '0;
      i_data <= '0;
    end else begin
      if (i_start) begin
        m_q.delete();
        m_pops = 0;
      end
      if (o_push && i_ready) m_q.push_back(o_data[15:0]);
      if (o_pop && i_ready) begin
        r = 16'h0;
        if (m_q.size() > 0) begin
          idx = 0;
          if (!fifo_mode)
            for (int k = 1; k < m_q.size(); k++)
              if (m_q[k] < m_q[idx]) idx = k;
          r = m_q[idx];
          m_q.delete(idx);
        end
        if (m_pops == corrupt_idx) r = r + 16'd1;
        m_pops = m_pops + 1;
        p0 <= {{MTW{1'b0}}, r};
      end
      i_data <= p0;
    end
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_prio[8];
  logic [15:0] obs_prio[$];
  logic [31:0] obs_meta[$];
  int done_at, busy_cyc, hold_bad, both_bad, pushes, pops, done_after, timed_out;
  logic            fin_err;
  logic [CNTW-1:0] fin_err_cnt, fin_pop_cnt;

  // driver: start a run and watch it until o_done (or budget expires)
  task automatic do_run(input int n, input int rmode, input int max_cyc);
    logic r;
    logic hold_pend;
    logic [DW-1:0] held;
    int cyc;
    obs_prio.delete();
    obs_meta.delete();
    done_at = -1; busy_cyc = 0; hold_bad = 0; both_bad = 0;
    pushes = 0; pops = 0; timed_out = 0; done_after = 0;
    hold_pend = 1'b0; held = '0; cyc = 0;
    @(negedge clk);
    i_num_ops = CNTW'(n);
    i_start   = 1'b1;
    i_ready   = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    forever begin
      r = (rmode == 0) ? 1'b1 : ((cyc % 2) == 0);
      i_ready = r;
      if (o_busy) busy_cyc++;
      if (o_push && o_pop) both_bad++;
      if (hold_pend && (!o_push || o_data !== held)) hold_bad++;
      hold_pend = 1'b0;
      if (o_push && r) begin
        pushes++;
        obs_prio.push_back(o_data[15:0]);
        obs_meta.push_back(o_data[47:16]);
      end else if (o_push) begin
        hold_pend = 1'b1;
        held = o_data;
      end
      if (o_pop && r) pops++;
      if (o_done) begin
        done_at = cyc;
        fin_err = o_err;
        fin_err_cnt = o_err_cnt;
        fin_pop_cnt = o_pop_cnt;
        break;
      end
      if (cyc >= max_cyc) begin
        timed_out = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    done_after = o_done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (o_push !== 1'b0) begin errors++; $display("FAIL reset_push got %b want 0", o_push); end
    checks++; if (o_pop !== 1'b0) begin errors++; $display("FAIL reset_pop got %b want 0", o_pop); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", o_data); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", o_err); end
    checks++; if (o_err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", o_err_cnt); end
    checks++; if (o_pop_cnt !== '0) begin errors++; $display("FAIL reset_pop_cnt got %0d want 0", o_pop_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    fifo_mode = 1'b0; corrupt_idx = -1;
    do_run(4, 0, 300);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL basic_timeout got %0d want 0", timed_out); end
    checks++; if (pushes != 4) begin errors++; $display("FAIL basic_pushes got %0d want 4", pushes); end
    checks++; if (pops != 4) begin errors++; $display("FAIL basic_pops got %0d want 4", pops); end
    for (int i = 0; i < 4 && i < obs_prio.size(); i++) begin
      checks++; if (obs_prio[i] !== exp_prio[i]) begin errors++; $display("FAIL basic_prio[%0d] got %h want %h", i, obs_prio[i], exp_prio[i]); end
      checks++; if (obs_meta[i] !== 32'(i)) begin errors++; $display("FAIL basic_meta[%0d] got %0d want %0d", i, obs_meta[i], i); end
    end
    // 4 push + 20 gap + 4 pop + 2 drain cycles before DONE
    checks++; if (done_at != 30) begin errors++; $display("FAIL basic_done_at got %0d want 30", done_at); end
    checks++; if (busy_cyc != 30) begin errors++; $display("FAIL basic_busy_cyc got %0d want 30", busy_cyc); end
    checks++; if (fin_pop_cnt !== 8'd4) begin errors++; $display("FAIL basic_pop_cnt got %0d want 4", fin_pop_cnt); end
    checks++; if (fin_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", fin_err); end
    checks++; if (fin_err_cnt !== 8'd0) begin errors++; $display("FAIL basic_err_cnt got %0d want 0", fin_err_cnt); end
    checks++; if (done_after != 0) begin errors++; $display("FAIL basic_done_pulse got %0d want 0", done_after); end
    checks++; if (both_bad != 0) begin errors++; $display("FAIL basic_push_and_pop got %0d want 0", both_bad); end
  endtask

  task automatic test_stall();
    fifo_mode = 1'b0; corrupt_idx = -1;
    do_run(4, 1, 600);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL stall_timeout got %0d want 0", timed_out); end
    checks++; if (pushes != 4) begin errors++; $display("FAIL stall_pushes got %0d want 4", pushes); end
    for (int i = 0; i < 4 && i < obs_prio.size(); i++) begin
      checks++; if (obs_prio[i] !== exp_prio[i]) begin errors++; $display("FAIL stall_prio[%0d] got %h want %h", i, obs_prio[i], exp_prio[i]); end
    end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL stall_hold got %0d want 0", hold_bad); end
    checks++; if (pops != 4) begin errors++; $display("FAIL stall_pops got %0d want 4", pops); end
    checks++; if (fin_pop_cnt !== 8'd4) begin errors++; $display("FAIL stall_pop_cnt got %0d want 4", fin_pop_cnt); end
    checks++; if (fin_err !== 1'b0) begin errors++; $display("FAIL stall_err got %b want 0", fin_err); end
  endtask

  task automatic test_fifo_order();
    int exp_desc;
    exp_desc = 0;
    for (int i = 1; i < 8; i++) if (exp_prio[i] < exp_prio[i-1]) exp_desc++;
    fifo_mode = 1'b1; corrupt_idx = -1;
    do_run(8, 0, 600);
    fifo_mode = 1'b0;
    checks++; if (timed_out != 0) begin errors++; $display("FAIL fifo_timeout got %0d want 0", timed_out); end
    checks++; if (fin_err !== 1'b1) begin errors++; $display("FAIL fifo_err got %b want 1", fin_err); end
    checks++; if (fin_err_cnt !== CNTW'(exp_desc)) begin errors++; $display("FAIL fifo_err_cnt got %0d want %0d", fin_err_cnt, exp_desc); end
    checks++; if (fin_pop_cnt !== 8'd8) begin errors++; $display("FAIL fifo_pop_cnt got %0d want 8", fin_pop_cnt); end
  endtask

  task automatic test_zero_ops();
    do_run(0, 0, 40);
    checks++; if (done_at != 0) begin errors++; $display("FAIL zero_done_at got %0d want 0", done_at); end
    checks++; if (pushes != 0 || pops != 0) begin errors++; $display("FAIL zero_cmds got %0d/%0d want 0/0", pushes, pops); end
    checks++; if (fin_pop_cnt !== 8'd0) begin errors++; $display("FAIL zero_pop_cnt got %0d want 0", fin_pop_cnt); end
    checks++; if (fin_err !== 1'b0 || fin_err_cnt !== 8'd0) begin errors++; $display("FAIL zero_err got %b/%0d want 0/0", fin_err, fin_err_cnt); end
    checks++; if (done_after != 0) begin errors++; $display("FAIL zero_done_pulse got %0d want 0", done_after); end
  endtask

  task automatic test_reset_mid_run();
    int pops_seen, cyc, dones;
    fifo_mode = 1'b0; corrupt_idx = -1;
    @(negedge clk);
    i_num_ops = 8'd4; i_start = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    pops_seen = 0; cyc = 0;
    while (pops_seen < 2 && cyc < 200) begin
      if (o_pop) pops_seen++;
      @(negedge clk);
      cyc++;
    end
    checks++; if (pops_seen != 2) begin errors++; $display("FAIL midrst_reach_pop got %0d want 2", pops_seen); end
    checks++; if (o_pop !== 1'b1) begin errors++; $display("FAIL midrst_in_pop got %b want 1", o_pop); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({o_push, o_pop, o_busy, o_done, o_err} !== 5'b0) begin errors++; $display("FAIL midrst_flags got %b want 00000", {o_push, o_pop, o_busy, o_done, o_err}); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL midrst_data got %h want 0", o_data); end
    checks++; if (o_pop_cnt !== '0 || o_err_cnt !== '0) begin errors++; $display("FAIL midrst_cnts got %0d/%0d want 0/0", o_pop_cnt, o_err_cnt); end
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_done || o_busy) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dones); end
    do_run(3, 0, 300);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL restart_timeout got %0d want 0", timed_out); end
    checks++; if (fin_pop_cnt !== 8'd3) begin errors++; $display("FAIL restart_pop_cnt got %0d want 3", fin_pop_cnt); end
    checks++; if (fin_err !== 1'b0) begin errors++; $display("FAIL restart_err got %b want 0", fin_err); end
    for (int i = 0; i < 3 && i < obs_prio.size(); i++) begin
      checks++; if (obs_prio[i] !== exp_prio[i]) begin errors++; $display("FAIL restart_prio[%0d] got %h want %h", i, obs_prio[i], exp_prio[i]); end
    end
  endtask

  task automatic test_sumcheck();
    logic exp_err;
`ifdef PIFO_SEQ_SUMCHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    fifo_mode = 1'b0; corrupt_idx = 0;  // 389C popped as 389D, still ordered
    do_run(4, 0, 300);
    corrupt_idx = -1;
    checks++; if (timed_out != 0) begin errors++; $display("FAIL sum_timeout got %0d want 0", timed_out); end
    checks++; if (fin_err !== exp_err) begin errors++; $display("FAIL sum_err got %b want %b", fin_err, exp_err); end
    checks++; if (fin_err_cnt !== 8'd0) begin errors++; $display("FAIL sum_err_cnt got %0d want 0", fin_err_cnt); end
    checks++; if (fin_pop_cnt !== 8'd4) begin errors++; $display("FAIL sum_pop_cnt got %0d want 4", fin_pop_cnt); end
  endtask

  initial begin
    // Galois x^16+x^14+x^13+x^11+1 sequence from ACE1, worked by hand
    exp_prio[0] = 16'hACE1; exp_prio[1] = 16'hE270;
    exp_prio[2] = 16'h7138; exp_prio[3] = 16'h389C;
    exp_prio[4] = 16'h1C4E; exp_prio[5] = 16'h0E27;
    exp_prio[6] = 16'hB313; exp_prio[7] = 16'hED89;
    test_reset();
    test_basic();
    test_stall();
    test_fifo_order();
    test_zero_ops();
    test_reset_mid_run();
    test_sumcheck();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
